// File: rtl/codec_i2c_target_if.sv
// Bus bundle for the codec I2C target: the 2-wire port, the write-report
// outputs and the register-file read port. The master side is the bus driver.
interface codec_i2c_target_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe_o;
    logic       wr_valid_o;
    logic [6:0] wr_addr_o;
    logic [8:0] wr_data_o;
    logic [6:0] rd_addr_i;
    logic [8:0] rd_data_o;
    logic       busy_o;
    logic       err_o;

    modport master (
        output scl_i, sda_i, rd_addr_i,
        input  sda_oe_o, wr_valid_o, wr_addr_o, wr_data_o, rd_data_o, busy_o, err_o
    );

    modport slave (
        input  scl_i, sda_i, rd_addr_i,
        output sda_oe_o, wr_valid_o, wr_addr_o, wr_data_o, rd_data_o, busy_o, err_o
    );
endinterface

// File: rtl/codec_i2c_target.sv
// Write-only I2C target standing in for the audio codec control port.
// Define CODEC_I2C_TARGET_SOFT_RESET_EN to make a write to 7'h0F clear all registers.
module codec_i2c_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         NUM_REGS    = 10,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              clk_i2c,
    input  logic              reg_rstn,
    codec_i2c_target_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_A, BYTE0, ACK0, BYTE1, ACK1, WAIT_STOP
    } state_t;

    localparam logic [6:0] NUM_REGS_A = 7'(NUM_REGS);
`ifdef CODEC_I2C_TARGET_SOFT_RESET_EN
    localparam logic [6:0] SOFT_RST_ADDR = 7'h0F;
`endif

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s, sda_s;
    logic                   scl_q, sda_q;
    logic                   scl_rise, scl_fall;
    logic                   start_det, stop_det;

    state_t     state;
    logic [2:0] bit_cnt;
    logic       byte_done;
    logic [7:0] shift_q;
    logic [7:0] b0_q;
    logic [6:0] commit_addr;
    logic [8:0] commit_data;
    logic [8:0] regs [NUM_REGS];

    // Synchronisers idle high like the bus, so reset release never looks like an edge.
    always_ff @(posedge clk_i2c or negedge reg_rstn) begin
        if (!reg_rstn) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

    // At the end of ACK1 the shifter still holds B1: ACK clocks shift nothing in.
    assign commit_addr = b0_q[7:1];
    assign commit_data = {b0_q[0], shift_q};

    always_ff @(posedge clk_i2c or negedge reg_rstn) begin
        if (!reg_rstn) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            byte_done      <= 1'b0;
            shift_q        <= '0;
            b0_q           <= '0;
            bus.sda_oe_o   <= 1'b0;
            bus.wr_valid_o <= 1'b0;
            bus.wr_addr_o  <= '0;
            bus.wr_data_o  <= '0;
            bus.busy_o     <= 1'b0;
            bus.err_o      <= 1'b0;
            // NOTE: the register file must read 0 after reset, so it lives in flops with the async reset rather than in RAM.
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            bus.wr_valid_o <= 1'b0;
            if (start_det) begin
                state        <= ADDR;
                bit_cnt      <= '0;
                byte_done    <= 1'b0;
                bus.busy_o   <= 1'b1;
                bus.sda_oe_o <= 1'b0;
            end else if (stop_det) begin
                state        <= IDLE;
                bit_cnt      <= '0;
                byte_done    <= 1'b0;
                bus.busy_o   <= 1'b0;
                bus.sda_oe_o <= 1'b0;
            end else begin
                if (scl_rise && (state == ADDR || state == BYTE0 || state == BYTE1)) begin
                    shift_q <= {shift_q[6:0], sda_s};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) byte_done <= 1'b1;
                end
                if (scl_fall) begin
                    case (state)
                        ADDR: if (byte_done) begin
                            byte_done <= 1'b0;
                            if (shift_q == {DEV_ADDR, 1'b0}) begin
                                state        <= ACK_A;
                                bus.sda_oe_o <= 1'b1;
                            end else begin
                                state      <= IDLE;
                                bus.busy_o <= 1'b0;
                            end
                        end
                        ACK_A: begin
                            state        <= BYTE0;
                            bus.sda_oe_o <= 1'b0;
                        end
                        BYTE0: if (byte_done) begin
                            byte_done    <= 1'b0;
                            b0_q         <= shift_q;
                            state        <= ACK0;
                            bus.sda_oe_o <= 1'b1;
                        end
                        ACK0: begin
                            state        <= BYTE1;
                            bus.sda_oe_o <= 1'b0;
                        end
                        BYTE1: if (byte_done) begin
                            byte_done    <= 1'b0;
                            state        <= ACK1;
                            bus.sda_oe_o <= 1'b1;
                        end
                        ACK1: begin
                            state          <= WAIT_STOP;
                            bus.sda_oe_o   <= 1'b0;
                            bus.wr_valid_o <= 1'b1;
                            bus.wr_addr_o  <= commit_addr;
                            bus.wr_data_o  <= commit_data;
`ifdef CODEC_I2C_TARGET_SOFT_RESET_EN
                            if (commit_addr == SOFT_RST_ADDR) begin
                                for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
                            end else begin
                                for (int i = 0; i < NUM_REGS; i++)
                                    if (commit_addr == 7'(i)) regs[i] <= commit_data;
                                if (commit_addr >= NUM_REGS_A) bus.err_o <= 1'b1;
                            end
`else
                            for (int i = 0; i < NUM_REGS; i++)
                                if (commit_addr == 7'(i)) regs[i] <= commit_data;
                            if (commit_addr >= NUM_REGS_A) bus.err_o <= 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        bus.rd_data_o = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (bus.rd_addr_i == 7'(i)) bus.rd_data_o = regs[i];
    end

endmodule

// File: tb/tb_codec_i2c_target.sv
// Directed and randomized I2C write frames against a register-file model
// of the codec target; the bus is modelled as an open-drain wired-AND.
module tb_codec_i2c_target;

    localparam int         Q        = 4;   // clk_i2c cycles per quarter SCL period
    localparam int         NUM_REGS = 10;
    localparam logic [6:0] DEV      = 7'h1A;

    logic       clk_i2c = 1'b0;
    logic       reg_rstn = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [6:0] rd_addr = '0;

    int n_checks = 0;
    int n_errors = 0;
    int valid_cycles = 0;
    int oe_cycles = 0;
    int busy_cycles = 0;

    logic [8:0] m_regs [NUM_REGS];
    logic       m_err;

    codec_i2c_target_if bus ();

    assign bus.scl_i     = scl_m;
    assign bus.sda_i     = sda_m & ~bus.sda_oe_o;
    assign bus.rd_addr_i = rd_addr;

    codec_i2c_target dut (
        .clk_i2c  (clk_i2c),
        .reg_rstn (reg_rstn),
        .bus      (bus)
    );

    always #5 clk_i2c = ~clk_i2c;

    always @(negedge clk_i2c) begin
        if (bus.wr_valid_o) valid_cycles++;
        if (bus.sda_oe_o)   oe_cycles++;
        if (bus.busy_o)     busy_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        m_err = 1'b0;
    endfunction

    function automatic void model_commit(input logic [6:0] a, input logic [8:0] d);
`ifdef CODEC_I2C_TARGET_SOFT_RESET_EN
        if (a == 7'h0F) begin
            for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
            return;
        end
`endif
        if (int'(a) < NUM_REGS) m_regs[int'(a)] = d;
        else m_err = 1'b1;
    endfunction

    task automatic wait_q(input int n = 1);
        repeat (n * Q) @(negedge clk_i2c);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; wait_q();
            scl_m = 1'b1; wait_q(2);
            scl_m = 1'b0; wait_q();
        end
    endtask

    // Ninth clock: master releases SDA and reads the line mid-high.
    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        ack = ~bus.sda_i;
        wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_addr = 7'(i);
            #1;
            check($sformatf("%s rd R%0d", tag, i), 32'(bus.rd_data_o), 32'(m_regs[i]));
        end
        rd_addr = 7'($urandom_range(NUM_REGS, 127));
        #1;
        check($sformatf("%s rd out-of-range %0h", tag, rd_addr), 32'(bus.rd_data_o), 32'd0);
        rd_addr = '0;
    endtask

    // Full frame: address byte, two payload bytes, optional extra bytes, STOP.
    task automatic run_write(input string tag, input logic [7:0] addr_byte,
                             input logic [15:0] payload, input int n_extra);
        logic       accepted;
        logic [3:0] acks;
        logic [3:0] exp_acks;
        logic       ack;
        logic       busy_after_addr;
        int         v0, oe0;
        accepted = (addr_byte == {DEV, 1'b0});
        v0  = valid_cycles;
        oe0 = oe_cycles;
        acks = '0;
        i2c_start();
        send_byte(addr_byte, ack); acks[0] = ack;
        busy_after_addr = bus.busy_o;
        send_byte(payload[15:8], ack); acks[1] = ack;
        send_byte(payload[7:0], ack);  acks[2] = ack;
        for (int i = 0; i < n_extra; i++) begin
            send_byte(8'($urandom), ack);
            acks[3] = acks[3] | ack;
        end
        i2c_stop();
        wait_q(2);
        exp_acks = accepted ? 4'b0111 : 4'b0000;
        check({tag, " acks"}, 32'(acks), 32'(exp_acks));
        check({tag, " busy after addr"}, 32'(busy_after_addr), 32'(accepted));
        check({tag, " wr_valid cycles"}, 32'(valid_cycles - v0), accepted ? 32'd1 : 32'd0);
        if (!accepted)
            check({tag, " sda_oe cycles"}, 32'(oe_cycles - oe0), 32'd0);
        if (accepted) begin
            model_commit(payload[15:9], payload[8:0]);
            check({tag, " wr_addr"}, 32'(bus.wr_addr_o), 32'(payload[15:9]));
            check({tag, " wr_data"}, 32'(bus.wr_data_o), 32'(payload[8:0]));
        end
        check({tag, " busy idle"}, 32'(bus.busy_o), 32'd0);
        check({tag, " err"}, 32'(bus.err_o), 32'(m_err));
        check_regs(tag);
    endtask

    initial begin
        logic       ack;
        logic       ok;
        logic [7:0] ab;
        int         v0, b0;

        model_reset();
        repeat (3) @(negedge clk_i2c);
        check("reset sda_oe", 32'(bus.sda_oe_o), 32'd0);
        check("reset wr_valid", 32'(bus.wr_valid_o), 32'd0);
        check("reset busy", 32'(bus.busy_o), 32'd0);
        check("reset err", 32'(bus.err_o), 32'd0);
        check("reset wr_addr", 32'(bus.wr_addr_o), 32'd0);
        check("reset wr_data", 32'(bus.wr_data_o), 32'd0);
        reg_rstn = 1'b1;
        repeat (4) @(negedge clk_i2c);
        check_regs("reset");

        // T1
        b0 = busy_cycles;
        run_write("T1", {DEV, 1'b0}, 16'h0c10, 0);
        check("T1 busy seen", 32'(busy_cycles > b0), 32'd1);

        // T2: wrong device address, then a read request
        run_write("T2 addr 1B", {7'h1B, 1'b0}, 16'h0c55, 0);
        run_write("T2 read", {DEV, 1'b1}, 16'h0c55, 0);

        // T3: frame dropped after B0, then the full frame
        v0 = valid_cycles;
        i2c_start();
        send_byte({DEV, 1'b0}, ack);
        check("T3 addr ack", 32'(ack), 32'd1);
        send_byte(8'h05, ack);
        check("T3 b0 ack", 32'(ack), 32'd1);
        i2c_stop();
        wait_q(2);
        check("T3 partial no write", 32'(valid_cycles - v0), 32'd0);
        check("T3 partial busy", 32'(bus.busy_o), 32'd0);
        check_regs("T3 partial");
        run_write("T3 full", {DEV, 1'b0}, 16'h0579, 0);

        // T4: last register, plus an unacknowledged fourth byte
        run_write("T4", {DEV, 1'b0}, 16'h1201, 1);

        // T5: address 7'h0F
        run_write("T5", {DEV, 1'b0}, 16'h1e00, 0);

        // T6: async reset while the target drives the B0 acknowledge
        i2c_start();
        send_byte({DEV, 1'b0}, ack);
        send_bits(8'h0c);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        check("T6 oe before reset", 32'(bus.sda_oe_o), 32'd1);
        reg_rstn = 1'b0;
        #1;
        check("T6 oe in reset", 32'(bus.sda_oe_o), 32'd0);
        model_reset();
        repeat (2) @(negedge clk_i2c);
        check("T6 busy in reset", 32'(bus.busy_o), 32'd0);
        reg_rstn = 1'b1;
        wait_q(2);
        check_regs("T6 after reset");
        run_write("T6 rewrite", {DEV, 1'b0}, 16'h0c10, 0);

        // Randomized frames
        for (int n = 0; n < 20; n++) begin
            ok = ($urandom_range(0, 3) != 0);
            ab = ok ? {DEV, 1'b0} : 8'($urandom);
            run_write($sformatf("rnd%0d", n), ab,
                      {7'($urandom_range(0, 15)), 9'($urandom_range(0, 511))},
                      int'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
